// File: rtl/timed_rr_arbiter.sv
// Timed round-robin arbiter: one resource, N requesters, bounded slice + guard gap.
// Ports: clk, reset (sync, active-high), req[N], done[N] -> gnt[N], gnt_id, busy, timeout.
// Option: define TIMED_ARB_PRIO0_EN to give requester 0 absolute priority.
module timed_rr_arbiter #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int T_SLICE = 8,
  parameter int T_GUARD = 2,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    done,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [TW-1:0] SLICE_END = TW'(T_SLICE - 1);
  localparam logic [TW-1:0] GUARD_END = TW'(T_GUARD - 1);
  localparam logic [TW-1:0] T_MAX     = '1;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] win;
  logic            win_ok;
  logic            start;
  logic            load_ptr;
  logic            own_done;
  logic            own_req;
  logic            expired;
  logic            timeout_d;
  logic [N-1:0]    gnt_d;
  logic [ID_W-1:0] gnt_id_d;
  int              idx;

  // Rotating search starting just after the last winner.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!win_ok && req[idx]) begin
        win_ok = 1'b1;
        win    = ID_W'(idx);
      end
    end
`ifdef TIMED_ARB_PRIO0_EN
    // Requester 0 overrides; ptr is left alone so 1..N-1 keep their order.
    load_ptr = !req[0];
    if (req[0]) begin
      win_ok = 1'b1;
      win    = '0;
    end
`else
    load_ptr = 1'b1;
`endif
  end

  assign own_done = done[gnt_id];
  assign own_req  = req[gnt_id];
  assign expired  = (t_q >= SLICE_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      ptr_q   <= ID_W'(N - 1);
      gnt     <= '0;
      gnt_id  <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      timeout <= timeout_d;
      if (start && load_ptr) ptr_q <= win;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          state_d = GRANT;
          start   = 1'b1;
        end
      end
      GRANT: begin
        if (own_done || !own_req || expired) begin
          state_d   = GUARD;
          // Only a pure slice expiry counts as a timeout.
          timeout_d = expired && !own_done && own_req;
        end
      end
      GUARD: begin
        if (t_q >= GUARD_END) begin
          if (win_ok) begin
            state_d = GRANT;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) t_d = '0;
    else if (t_q == T_MAX)  t_d = t_q;
    else                    t_d = t_q + TW'(1);
  end

  always_comb begin
    gnt_d    = '0;
    gnt_id_d = gnt_id;
    if (start) begin
      gnt_d    = N'(1) << win;
      gnt_id_d = win;
    end else if (state_d == GRANT) begin
      gnt_d    = gnt;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
